// File: rtl/wshb_burst_ram.sv
// rtl/wshb_burst_ram.sv - Wishbone registered-feedback burst RAM slave
module wshb_burst_ram #(
    parameter int DATA_BYTES = 4,
    parameter int MEM_AW     = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             adr,
    input  logic [8*DATA_BYTES-1:0] dat_ms,
    output logic [8*DATA_BYTES-1:0] dat_sm,
    input  logic [DATA_BYTES-1:0]   sel,
    input  logic                    cyc,
    input  logic                    stb,
    input  logic                    we,
    input  logic [2:0]              cti,
    input  logic [1:0]              bte,
    output logic                    ack,
    output logic                    err,
    output logic                    rty
);
    localparam int BA = $clog2(DATA_BYTES);
    localparam int DW = 8 * DATA_BYTES;

    typedef enum logic [1:0] {IDLE, SINGLE, BURST} state_t;
    state_t state, state_nx;

    logic [DW-1:0]     mem [0:(1<<MEM_AW)-1];
    logic [DW-1:0]     rd_q, last_q, cur_word, merged;
    logic [MEM_AW-1:0] badr, adv, req_idx, wrap_mask;
    logic [31:0]       word_adr, req_hi, hi_q;
    logic              live, match, hit, oor_q, burst_cti, load, advance, wr_en;

    assign word_adr  = adr >> BA;
    assign req_idx   = word_adr[MEM_AW-1:0];
    assign req_hi    = word_adr >> MEM_AW;
    assign oor_q     = (hi_q != '0);
    assign live      = cyc & stb;
    assign match     = (req_idx == badr) && (req_hi == hi_q);
    assign burst_cti = (cti == 3'b001) || (cti == 3'b010);

    // Termination is the registered state gated by the live strobe; a burst
    // beat only terminates when the master follows the predicted address.
    assign hit   = live & ((state == SINGLE) | ((state == BURST) & match));
    assign ack   = hit & ~oor_q;
    assign err   = hit & oor_q;
    assign rty   = 1'b0;
    assign wr_en = ack & we;

    assign dat_sm = (ack | err) ? rd_q : last_q;

    always_comb begin
        case (bte)
            2'b01:   wrap_mask = MEM_AW'(32'd3);
            2'b10:   wrap_mask = MEM_AW'(32'd7);
            2'b11:   wrap_mask = MEM_AW'(32'd15);
            default: wrap_mask = '1;
        endcase
        adv = badr;
        if (cti == 3'b010)
            adv = (badr & ~wrap_mask) | ((badr + MEM_AW'(1)) & wrap_mask);
    end

    always_comb begin
        cur_word = mem[badr];
        merged   = cur_word;
        for (int i = 0; i < DATA_BYTES; i++)
            if (sel[i])
                merged[8*i +: 8] = dat_ms[8*i +: 8];
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        advance  = 1'b0;
        case (state)
            IDLE: begin
                if (live) begin
                    load     = 1'b1;
                    state_nx = burst_cti ? BURST : SINGLE;
                end
            end
            SINGLE: begin
                if (!cyc || stb)
                    state_nx = IDLE;
            end
            BURST: begin
                if (!cyc) begin
                    state_nx = IDLE;
                end else if (stb) begin
                    if (match) begin
                        if (burst_cti)
                            advance = 1'b1;
                        else
                            state_nx = IDLE;
                    end else begin
                        load     = 1'b1;
                        state_nx = burst_cti ? BURST : SINGLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Prefetch forwards the beat being written when the address does not move.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            badr   <= '0;
            hi_q   <= '0;
            rd_q   <= '0;
            last_q <= '0;
        end else begin
            last_q <= dat_sm;
            if (load) begin
                badr <= req_idx;
                hi_q <= req_hi;
                rd_q <= (req_hi != '0) ? '0 : mem[req_idx];
            end else if (advance) begin
                badr <= adv;
                if (oor_q)
                    rd_q <= '0;
                else if (wr_en && (adv == badr))
                    rd_q <= merged;
                else
                    rd_q <= mem[adv];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[badr] <= merged;
    end
endmodule

// File: tb/tb_wshb_burst_ram.sv
// tb/tb_wshb_burst_ram.sv - scoreboard bench for wshb_burst_ram
module tb_wshb_burst_ram;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr, dat_ms, dat_sm;
    logic [3:0]  sel;
    logic        cyc, stb, we, ack, err, rty;
    logic [2:0]  cti;
    logic [1:0]  bte;

    int errors = 0;
    int checks = 0;
    logic [31:0] model [0:1023];
    logic [31:0] exp_q [$];

    wshb_burst_ram #(.DATA_BYTES(4), .MEM_AW(10)) dut (
        .clk(clk), .rst(rst), .adr(adr), .dat_ms(dat_ms), .dat_sm(dat_sm),
        .sel(sel), .cyc(cyc), .stb(stb), .we(we), .cti(cti), .bte(bte),
        .ack(ack), .err(err), .rty(rty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int nxt(input int i, input logic [1:0] bt);
        int m;
        case (bt)
            2'b00:   m = 1023;
            2'b01:   m = 3;
            2'b10:   m = 7;
            default: m = 15;
        endcase
        return (i & ~m) | ((i + 1) & m);
    endfunction

    always @(negedge clk) begin
        if (!rst && ack && !we) begin
            if (exp_q.size() == 0)
                chk("sb_underflow", 32'd1, 32'd0);
            else
                chk("rd_data", dat_sm, exp_q.pop_front());
        end
    end

    // Starts and ends one time unit after a rising edge.
    task automatic single(input logic [31:0] a, input bit w, input logic [31:0] d,
                          input logic [3:0] s, input bit exp_err);
        int idx;
        idx = int'(a[11:2]);
        adr = a; we = w; dat_ms = d; sel = s; cti = 3'b000; bte = 2'b00;
        cyc = 1'b1; stb = 1'b1;
        if (!w && !exp_err) exp_q.push_back(model[idx]);
        @(negedge clk);
        chk("single_lat0", {30'd0, ack, err}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("single_term", {30'd0, ack, err}, exp_err ? 32'd1 : 32'd2);
        chk("single_rty", {31'd0, rty}, 32'd0);
        if (exp_err) chk("err_data", dat_sm, 32'd0);
        if (w && !exp_err)
            for (int i = 0; i < 4; i++)
                if (s[i]) model[idx][8*i +: 8] = d[8*i +: 8];
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic burst(input int start, input logic [2:0] mode, input logic [1:0] bt,
                         input int n, input bit wr, input int stall_beat,
                         input int abort_after, input int jump_beat, input int jump_idx);
        int idx, lat;
        logic [31:0] d;
        idx = start;
        cyc = 1'b1; bte = bt;
        for (int b = 0; b < n; b++) begin
            if (b == stall_beat) begin
                stb = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    chk("stall_ack", {31'd0, ack}, 32'd0);
                    @(posedge clk); #1;
                end
            end
            if (b == jump_beat) idx = jump_idx;
            d = $urandom();
            adr = 32'(idx) << 2; we = wr; dat_ms = d; sel = 4'hF;
            cti = (b == n - 1) ? 3'b111 : mode;
            stb = 1'b1;
            if (!wr) exp_q.push_back(model[idx]);
            lat = 0;
            forever begin
                @(negedge clk);
                if (ack || err) break;
                lat++;
                if (lat > 4) break;
            end
            chk("beat_lat", 32'(lat), (b == 0 || b == jump_beat) ? 32'd1 : 32'd0);
            if (wr && ack) model[idx] = d;
            @(posedge clk); #1;
            if (mode == 3'b010) idx = nxt(idx, bt);
            if (b + 1 == abort_after) begin
                cyc = 1'b0; stb = 1'b0; we = 1'b0;
                @(negedge clk);
                chk("abort_ack", {31'd0, ack}, 32'd0);
                @(posedge clk); #1;
                return;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) model[i] = 32'd0;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0;
        dat_ms = '0; sel = '0; cti = '0; bte = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_rty", {31'd0, rty}, 32'd0);
        chk("rst_dat", dat_sm, 32'd0);
        rst = 1'b0;

        single(32'h10, 1, 32'hA5A5A5A5, 4'hF, 0);
        single(32'h10, 0, 32'h0, 4'hF, 0);
        single(32'h20, 1, 32'hFFFFFFFF, 4'hF, 0);
        single(32'h20, 1, 32'h11223344, 4'b0101, 0);
        single(32'h20, 0, 32'h0, 4'hF, 0);

        burst(5, 3'b010, 2'b01, 4, 1, -1, -1, -1, 0);
        burst(6, 3'b010, 2'b01, 4, 0, 2, -1, -1, 0);
        single(32'(5) << 2, 0, 32'h0, 4'hF, 0);

        burst(1022, 3'b010, 2'b00, 4, 1, -1, -1, -1, 0);
        burst(1022, 3'b010, 2'b00, 4, 0, -1, -1, -1, 0);

        burst(50, 3'b001, 2'b00, 3, 1, -1, -1, -1, 0);
        single(32'(50) << 2, 0, 32'h0, 4'hF, 0);

        single(32'(8) << 2, 1, 32'h08080808, 4'hF, 0);
        single(32'(9) << 2, 1, 32'h09090909, 4'hF, 0);
        burst(30, 3'b010, 2'b00, 2, 1, -1, -1, -1, 0);
        burst(8, 3'b010, 2'b00, 3, 0, -1, -1, 1, 30);

        single(32'h0, 1, 32'h12345678, 4'hF, 0);
        single(32'h1000, 1, 32'hCAFEF00D, 4'hF, 1);
        single(32'h1000, 0, 32'h0, 4'hF, 1);
        single(32'h0, 0, 32'h0, 4'hF, 0);

        single(32'(22) << 2, 1, 32'h22222222, 4'hF, 0);
        single(32'(23) << 2, 1, 32'h23232323, 4'hF, 0);
        burst(20, 3'b010, 2'b00, 4, 1, -1, 2, -1, 0);
        single(32'(22) << 2, 0, 32'h0, 4'hF, 0);
        single(32'(23) << 2, 0, 32'h0, 4'hF, 0);
        single(32'(20) << 2, 0, 32'h0, 4'hF, 0);
        single(32'(21) << 2, 0, 32'h0, 4'hF, 0);

        single(32'(40) << 2, 1, 32'h40404040, 4'hF, 0);
        single(32'(41) << 2, 1, 32'h41414141, 4'hF, 0);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; cti = 3'b010; bte = 2'b00; sel = 4'hF;
        adr = 32'(40) << 2; dat_ms = 32'hDEAD0040;
        @(negedge clk);
        @(negedge clk);
        chk("rb_b0_ack", {31'd0, ack}, 32'd1);
        model[40] = 32'hDEAD0040;
        @(posedge clk); #1;
        adr = 32'(41) << 2; dat_ms = 32'hDEAD0041;
        #1;
        chk("rb_pre_ack", {31'd0, ack}, 32'd1);
        #1; rst = 1'b1; #1;
        chk("rb_ack", {31'd0, ack}, 32'd0);
        chk("rb_err", {31'd0, err}, 32'd0);
        chk("rb_dat", dat_sm, 32'd0);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; rst = 1'b0;
        single(32'(41) << 2, 0, 32'h0, 4'hF, 0);
        single(32'(40) << 2, 0, 32'h0, 4'hF, 0);

        repeat (2) @(posedge clk);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wshb_burst_ram.md
WSHB_BURST_RAM -- requirements
Module: wshb_burst_ram

Interface
REQ-001 The block SHALL have parameter DATA_BYTES, default 4, giving the data bus width in bytes (legal values 1, 2, 4, 8).
REQ-002 The block SHALL have parameter MEM_AW, default 10, giving log2 of the memory depth in words.
REQ-003 The block SHALL have one clock, clk, and an asynchronous active-high reset, rst; all other ports SHALL be Wishbone slave signals, listed below.
REQ-004 clk  input  1  Clock; all state changes on its rising edge.
REQ-005 rst  input  1  Asynchronous reset, active high.
REQ-006 adr  input  32  Byte address.
REQ-007 dat_ms  input  8*DATA_BYTES  Write data from the master.
REQ-008 dat_sm  output  8*DATA_BYTES  Read data to the master.
REQ-009 sel  input  DATA_BYTES  Byte enables.
REQ-010 cyc, stb, we  input  1 each  Bus cycle, strobe and write enable.
REQ-011 cti  input  3  Cycle type identifier.
REQ-012 bte  input  2  Burst type extension.
REQ-013 ack, err, rty  output  1 each  Termination signals.

Function
REQ-014 Memory SHALL hold 2**MEM_AW words of 8*DATA_BYTES bits; word index = adr[MEM_AW+BA-1:BA], where BA = log2(DATA_BYTES); adr[BA-1:0] SHALL be ignored.
REQ-015 An access is out of range when any adr bit at or above MEM_AW+BA is 1: it SHALL terminate with err instead of ack, with identical timing, no memory write, and dat_sm = 0.
REQ-016 rty SHALL be constant 0.
REQ-017 State machine states SHALL be IDLE, SINGLE and BURST.
REQ-018 IDLE -> SINGLE on cyc&stb when cti is 000 or 111; IDLE -> BURST on cyc&stb when cti is 001 or 010; cti values 011-110 SHALL be treated as 000.
REQ-019 SINGLE SHALL assert ack (or err) for exactly one cycle, one cycle after the request is sampled (first-beat latency 1), then return to IDLE; back-to-back singles SHALL take 2 cycles each.
REQ-020 BURST: first beat acked at latency 1; each following beat SHALL be acked in the cycle immediately after the previous ack while stb stays high (1 beat/cycle).
REQ-021 Burst address advance after each acked beat: cti=001 -> unchanged; cti=010 -> word index +1, with bte 00 = linear (wraps modulo memory depth), 01/10/11 = wrap within an aligned 4/8/16-word block.
REQ-022 Burst read data SHALL be prefetched from the predicted next address so that dat_sm is valid in every ack cycle.
REQ-023 If adr differs from the predicted address while in BURST, the block SHALL withhold ack and restart as a new first beat (latency 1).
REQ-024 A beat acked with cti=111 SHALL end the burst and return to IDLE.
REQ-025 If stb drops mid-burst, ack SHALL stay low, the burst address SHALL be held, and resumption SHALL ack at latency 0 with the held prefetched data.
REQ-026 The ack and err outputs SHALL be a registered term ANDed with cyc&stb, so no termination is ever driven on an idle strobe.
REQ-027 If cyc drops in any state, the state SHALL return to IDLE on the next edge.
REQ-028 A write SHALL occur only in a cycle with ack&we; each byte lane i SHALL be written only when sel[i] = 1.
REQ-029 Read data SHALL ignore sel; dat_sm SHALL hold its last value outside ack cycles.

Reset
REQ-030 While rst = 1: state = IDLE, ack = 0, err = 0, rty = 0, dat_sm = 0, burst address = 0.
REQ-031 Memory contents SHALL NOT be reset.
REQ-032 Reset asserted mid-burst SHALL abort the burst immediately, with no further writes.
REQ-033 After rst deasserts, the first request SHALL see the normal first-beat latency of 1.

Verification
REQ-034 Single write then single read: write adr 0x10, dat_ms 0xA5A5A5A5, sel 1111, then read adr 0x10 -> ack 1 cycle after each request, read returns 0xA5A5A5A5.
REQ-035 Byte lanes: write 0x11223344 with sel 0101 over 0xFFFFFFFF, then read -> 0xFF22FF44.
REQ-036 Wrap-4 read burst: cti 010, bte 01, start word 6, master stalls on beat 2 -> word order 6,7,4,5, ack back-to-back except during the stall, last beat cti 111 -> IDLE.
REQ-037 Out-of-range access: adr = 1<<(MEM_AW+BA) -> err pulse, ack 0, memory unchanged.
REQ-038 Control aborts: cyc dropped after 2 beats of a linear write burst -> only 2 words written, IDLE next cycle; rst pulse mid-burst -> all outputs 0 immediately.
